fwd_scoreboard_unit: RTL and testbench

- Parametrised successor to the fixed two-stage forwarding logic.
- Tracks in-flight register writes in a DEPTH-slot shift scoreboard that mirrors the post-EX pipeline latches.
- Produces per-source forwarding selects for NSRC operands and a load-use hazard stall.
- Keeps saturating performance counters; sits beside the ID/EX latch and feeds the EX-stage operand muxes and the hazard unit.

---
 rtl/fwd_scoreboard_unit.sv | 95 +++++++++
 tb/tb_fwd_scoreboard_unit.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fwd_scoreboard_unit.sv
// Forwarding scoreboard: tracks in-flight register writes behind EX, resolves
// per-operand forwarding selects, flags load-use hazards and counts events.
module fwd_scoreboard_unit #(
   parameter int AW    = 5,
   parameter int NSRC  = 2,
   parameter int DEPTH = 2,
   parameter int SELW  = $clog2(DEPTH + 1),
   parameter int CW    = 32
) (
   input  logic                   CLK,
   input  logic                   nRST,
   input  logic                   advance,
   input  logic                   flush,
   input  logic                   ex_wen,
   input  logic [AW-1:0]          ex_dest,
   input  logic                   ex_is_load,
   input  logic [NSRC*AW-1:0]     src_addr,
   input  logic [NSRC-1:0]        src_used,
   output logic [NSRC*SELW-1:0]   fwd_sel,
   output logic                   hazard_stall,
   output logic [CW-1:0]          stall_cnt,
   output logic [CW-1:0]          fwd_cnt
);

   localparam int NW = $clog2(NSRC + 1);

   logic [DEPTH-1:0] slot_valid;
   logic [DEPTH-1:0] slot_load;
   logic [AW-1:0]    slot_dest [DEPTH];
   logic [NW-1:0]    fwd_num;
   logic [CW:0]      fwd_sum;
   logic [AW-1:0]    src;
   logic             hit;

   // Youngest matching slot wins; a load still in slot 0 cannot forward yet.
   always_comb begin
      fwd_sel      = '0;
      hazard_stall = 1'b0;
      fwd_num      = '0;
      src          = '0;
      hit          = 1'b0;
      for (int i = 0; i < NSRC; i++) begin
         src = src_addr[i*AW +: AW];
         hit = 1'b0;
         for (int k = 0; k < DEPTH; k++) begin
            if (!hit && slot_valid[k] && (slot_dest[k] == src) && src_used[i] && (src != '0)) begin
               hit = 1'b1;
               if ((k == 0) && slot_load[k]) begin
                  hazard_stall = 1'b1;
               end else begin
                  fwd_sel[i*SELW +: SELW] = SELW'(k + 1);
                  fwd_num = fwd_num + NW'(1);
               end
            end
         end
      end
   end

   assign fwd_sum = {1'b0, fwd_cnt} + {{(CW + 1 - NW){1'b0}}, fwd_num};

   // A stalled or flushed EX instruction enters as a bubble.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         slot_valid <= '0;
         slot_load  <= '0;
         for (int k = 0; k < DEPTH; k++) begin
            slot_dest[k] <= '0;
         end
      end else if (advance) begin
         for (int k = DEPTH - 1; k > 0; k--) begin
            slot_valid[k] <= slot_valid[k-1];
            slot_load[k]  <= slot_load[k-1];
            slot_dest[k]  <= slot_dest[k-1];
         end
         slot_valid[0] <= ex_wen & (ex_dest != '0) & ~flush & ~hazard_stall;
         slot_load[0]  <= ex_is_load;
         slot_dest[0]  <= ex_dest;
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         stall_cnt <= '0;
         fwd_cnt   <= '0;
      end else if (advance) begin
         if (hazard_stall && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CW'(1);
         end
         if (!hazard_stall) begin
            fwd_cnt <= fwd_sum[CW] ? '1 : fwd_sum[CW-1:0];
         end
      end
   end

endmodule

// File: tb/tb_fwd_scoreboard_unit.sv
// Scoreboard bench for fwd_scoreboard_unit: a default instance (DEPTH 2, NSRC 2)
// and a wide instance (DEPTH 4, NSRC 3, 3-bit counters) against a history model.
module tb_fwd_scoreboard_unit;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   bit       c_adv  [2];
   bit       c_fl   [2];
   bit       c_wen  [2];
   bit       c_ld   [2];
   bit [4:0] c_dest [2];
   bit [4:0] c_src  [2][3];
   bit [2:0] c_used [2];

   logic [3:0]  sel0;
   logic        hz0;
   logic [31:0] sc0, fc0;
   logic [8:0]  sel1;
   logic        hz1;
   logic [2:0]  sc1, fc1;

   fwd_scoreboard_unit #(.AW(5), .NSRC(2), .DEPTH(2), .CW(32)) dut0 (
      .CLK(clk), .nRST(rst_n), .advance(c_adv[0]), .flush(c_fl[0]),
      .ex_wen(c_wen[0]), .ex_dest(c_dest[0]), .ex_is_load(c_ld[0]),
      .src_addr({c_src[0][1], c_src[0][0]}), .src_used(c_used[0][1:0]),
      .fwd_sel(sel0), .hazard_stall(hz0), .stall_cnt(sc0), .fwd_cnt(fc0)
   );

   fwd_scoreboard_unit #(.AW(5), .NSRC(3), .DEPTH(4), .SELW(3), .CW(3)) dut1 (
      .CLK(clk), .nRST(rst_n), .advance(c_adv[1]), .flush(c_fl[1]),
      .ex_wen(c_wen[1]), .ex_dest(c_dest[1]), .ex_is_load(c_ld[1]),
      .src_addr({c_src[1][2], c_src[1][1], c_src[1][0]}), .src_used(c_used[1]),
      .fwd_sel(sel1), .hazard_stall(hz1), .stall_cnt(sc1), .fwd_cnt(fc1)
   );

   // Model: list of the most recent instructions to leave EX, youngest first.
   typedef struct {bit v; int d; bit ld;} ent_t;
   ent_t             hist [2][4];
   longint unsigned  m_stall [2];
   longint unsigned  m_fwd   [2];
   longint unsigned  cmax    [2];
   int               depth   [2];
   int               nsrc    [2];

   typedef struct {string tag; int inst; int sel[3]; bit hz; longint unsigned sc; longint unsigned fc;} exp_t;
   typedef struct {string tag; int inst; int kind; longint unsigned val;} chk_t;
   exp_t expq[$];
   chk_t chkq[$];

   int checks   = 0;
   int failures = 0;

   task automatic compareVal(string name, longint unsigned act, longint unsigned req);
      checks++;
      if (act != req) begin
         failures++;
         $display("[TB] FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   // kind 0..2 = select of that operand, 3 = hazard, 4 = stall_cnt, 5 = fwd_cnt
   function automatic longint unsigned dutVal(int inst, int kind);
      if (inst == 0) begin
         case (kind)
            0, 1:    return longint'(sel0[kind*2 +: 2]);
            3:       return longint'(hz0);
            4:       return longint'(sc0);
            default: return longint'(fc0);
         endcase
      end else begin
         case (kind)
            0, 1, 2: return longint'(sel1[kind*3 +: 3]);
            3:       return longint'(hz1);
            4:       return longint'(sc1);
            default: return longint'(fc1);
         endcase
      end
   endfunction

   function automatic void modelEval(int inst, output int sel[3], output bit hz, output int nf);
      hz = 1'b0;
      nf = 0;
      for (int i = 0; i < 3; i++) begin
         sel[i] = 0;
         if (i < nsrc[inst] && c_used[inst][i] && c_src[inst][i] != 0) begin
            for (int k = 0; k < depth[inst]; k++) begin
               if (hist[inst][k].v && hist[inst][k].d == int'(c_src[inst][i])) begin
                  if (k == 0 && hist[inst][k].ld) hz = 1'b1;
                  else begin
                     sel[i] = k + 1;
                     nf++;
                  end
                  break;
               end
            end
         end
      end
   endfunction

   function automatic void modelReset();
      for (int n = 0; n < 2; n++) begin
         m_stall[n] = 0;
         m_fwd[n]   = 0;
         for (int k = 0; k < 4; k++) hist[n][k] = '{0, 0, 0};
      end
   endfunction

   function automatic void pushExpected(int inst, string tag);
      exp_t e;
      int   nf;
      e.tag  = tag;
      e.inst = inst;
      modelEval(inst, e.sel, e.hz, nf);
      e.sc = m_stall[inst];
      e.fc = m_fwd[inst];
      expq.push_back(e);
   endfunction

   function automatic void modelClock(int inst);
      int sel[3];
      bit hz;
      int nf;
      modelEval(inst, sel, hz, nf);
      if (!c_adv[inst]) return;
      for (int k = depth[inst] - 1; k > 0; k--) hist[inst][k] = hist[inst][k-1];
      hist[inst][0] = '{c_wen[inst] && c_dest[inst] != 0 && !c_fl[inst] && !hz, int'(c_dest[inst]), c_ld[inst]};
      if (hz) m_stall[inst] = (m_stall[inst] + 1 > cmax[inst]) ? cmax[inst] : m_stall[inst] + 1;
      else    m_fwd[inst]   = (m_fwd[inst] + nf > cmax[inst]) ? cmax[inst] : m_fwd[inst] + nf;
   endfunction

   task automatic applyStimulus(int inst, bit adv, bit fl, bit wen, int dest, bit ld,
                                int s0, int s1, int s2, bit [2:0] used, string tag);
      @(posedge clk);
      #1;
      c_adv[inst]    = adv;
      c_fl[inst]     = fl;
      c_wen[inst]    = wen;
      c_dest[inst]   = 5'(dest);
      c_ld[inst]     = ld;
      c_src[inst][0] = 5'(s0);
      c_src[inst][1] = 5'(s1);
      c_src[inst][2] = 5'(s2);
      c_used[inst]   = used;
      pushExpected(inst, tag);
      modelClock(inst);
   endtask

   task automatic checkOutput(string tag, int inst, int kind, longint unsigned val);
      chkq.push_back('{tag, inst, kind, val});
   endtask

   task automatic setIdle(int inst);
      c_adv[inst] = 0; c_fl[inst] = 0; c_wen[inst] = 0; c_dest[inst] = 0; c_ld[inst] = 0;
      for (int i = 0; i < 3; i++) c_src[inst][i] = 0;
      c_used[inst] = 0;
   endtask

   task automatic applyReset();
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      modelReset();
      for (int n = 0; n < 2; n++) begin
         c_adv[n] = 1'($urandom); c_fl[n] = 1'($urandom); c_wen[n] = 1'($urandom);
         c_dest[n] = 5'($urandom); c_ld[n] = 1'($urandom); c_used[n] = 3'($urandom);
         for (int i = 0; i < 3; i++) c_src[n][i] = 5'($urandom);
         pushExpected(n, "reset");
      end
      for (int kind = 0; kind < 6; kind++) if (kind != 2) checkOutput("reset_const", 0, kind, 0);
      @(posedge clk);
      #1;
      setIdle(0);
      setIdle(1);
      rst_n = 1'b1;
      pushExpected(0, "reset_release");
      pushExpected(1, "reset_release");
   endtask

   // Monitor: every cycle the DUT presents outputs, drain what the stimulus queued.
   initial begin
      forever begin
         @(negedge clk);
         while (expq.size() > 0) begin
            exp_t e;
            e = expq.pop_front();
            for (int i = 0; i < nsrc[e.inst]; i++)
               compareVal($sformatf("%s.u%0d.sel%0d", e.tag, e.inst, i), dutVal(e.inst, i), longint'(e.sel[i]));
            compareVal($sformatf("%s.u%0d.hazard", e.tag, e.inst), dutVal(e.inst, 3), longint'(e.hz));
            compareVal($sformatf("%s.u%0d.stall_cnt", e.tag, e.inst), dutVal(e.inst, 4), e.sc);
            compareVal($sformatf("%s.u%0d.fwd_cnt", e.tag, e.inst), dutVal(e.inst, 5), e.fc);
         end
         while (chkq.size() > 0) begin
            chk_t c;
            c = chkq.pop_front();
            compareVal($sformatf("%s.u%0d.k%0d", c.tag, c.inst, c.kind), dutVal(c.inst, c.kind), c.val);
         end
      end
   end

   initial begin
      depth = '{2, 4};
      nsrc  = '{2, 3};
      cmax  = '{64'hFFFF_FFFF, 64'd7};
      rst_n = 1'b1;
      setIdle(0);
      setIdle(1);
      modelReset();
      applyReset();

      applyStimulus(0, 1, 0, 0, 0, 0, 5, 6, 0, 3'b011, "idle");
      checkOutput("idle_sel0", 0, 0, 0);
      checkOutput("idle_sel1", 0, 1, 0);

      applyStimulus(0, 1, 0, 1, 8, 0, 0, 0, 0, 3'b000, "alu_ins");
      applyStimulus(0, 1, 0, 0, 0, 0, 8, 0, 0, 3'b001, "alu_s1");
      checkOutput("alu_sel_1", 0, 0, 1);
      applyStimulus(0, 1, 0, 0, 0, 0, 8, 0, 0, 3'b001, "alu_s2");
      checkOutput("alu_sel_2", 0, 0, 2);
      applyStimulus(0, 1, 0, 0, 0, 0, 8, 0, 0, 3'b001, "alu_s0");
      checkOutput("alu_sel_0", 0, 0, 0);
      checkOutput("alu_fwd_cnt", 0, 5, 2);

      applyStimulus(0, 1, 0, 1, 9, 0, 0, 0, 0, 3'b000, "young_a");
      applyStimulus(0, 1, 0, 1, 9, 0, 0, 0, 0, 3'b000, "young_b");
      applyStimulus(0, 1, 0, 0, 0, 0, 0, 9, 0, 3'b010, "young");
      checkOutput("youngest_sel1", 0, 1, 1);
      applyStimulus(0, 1, 0, 1, 0, 0, 0, 0, 0, 3'b011, "r0_ins");
      applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 0, 3'b011, "r0");
      checkOutput("reg0_sel0", 0, 0, 0);

      applyStimulus(0, 1, 0, 1, 4, 1, 0, 0, 0, 3'b000, "lw_ins");
      applyStimulus(0, 0, 0, 1, 12, 0, 4, 0, 0, 3'b001, "lw_hold");
      checkOutput("lw_hazard", 0, 3, 1);
      checkOutput("lw_sel0", 0, 0, 0);
      applyStimulus(0, 1, 0, 1, 12, 0, 4, 0, 0, 3'b001, "lw_stall");
      checkOutput("lw_hold_stall_cnt", 0, 4, 0);
      checkOutput("lw_hazard_adv", 0, 3, 1);
      applyStimulus(0, 1, 0, 0, 0, 0, 4, 12, 0, 3'b011, "lw_after");
      checkOutput("lw_after_hazard", 0, 3, 0);
      checkOutput("lw_after_sel0", 0, 0, 2);
      checkOutput("lw_bubble_sel1", 0, 1, 0);
      checkOutput("lw_stall_cnt", 0, 4, 1);

      applyStimulus(0, 1, 1, 1, 3, 0, 0, 0, 0, 3'b000, "flush_ins");
      applyStimulus(0, 1, 0, 0, 0, 0, 3, 0, 0, 3'b001, "flush");
      checkOutput("flush_sel0", 0, 0, 0);
      applyStimulus(0, 1, 0, 1, 7, 1, 0, 0, 0, 3'b000, "unused_ins");
      applyStimulus(0, 1, 0, 0, 0, 0, 7, 0, 0, 3'b000, "unused");
      checkOutput("unused_sel0", 0, 0, 0);
      checkOutput("unused_hazard", 0, 3, 0);

      for (int n = 0; n < 300; n++)
         applyStimulus(0, $urandom_range(0, 9) < 8, $urandom_range(0, 9) == 0, 1'($urandom),
                       $urandom_range(0, 7), $urandom_range(0, 2) == 0, $urandom_range(0, 7),
                       $urandom_range(0, 7), 0, 3'($urandom), "rand0");
      applyReset();
      for (int n = 0; n < 100; n++)
         applyStimulus(0, $urandom_range(0, 9) < 8, $urandom_range(0, 9) == 0, 1'($urandom),
                       $urandom_range(0, 7), $urandom_range(0, 2) == 0, $urandom_range(0, 7),
                       $urandom_range(0, 7), 0, 3'($urandom), "rand0b");
      setIdle(0);

      applyStimulus(1, 1, 0, 1, 7, 0, 0, 0, 0, 3'b000, "deep_ins");
      for (int k = 1; k <= 5; k++) begin
         applyStimulus(1, 1, 0, 0, 0, 0, 7, 7, 7, 3'b111, "deep");
         checkOutput($sformatf("deep_sel_k%0d", k), 1, k % 3, longint'(k % 5));
      end
      checkOutput("deep_fwd_sat", 1, 5, 7);
      applyStimulus(1, 1, 0, 0, 0, 0, 0, 0, 0, 3'b000, "deep_idle");
      checkOutput("deep_fwd_sat_hold", 1, 5, 7);
      for (int n = 0; n < 8; n++) begin
         applyStimulus(1, 1, 0, 1, 5, 1, 0, 0, 0, 3'b000, "lu_ins");
         applyStimulus(1, 1, 0, 0, 0, 0, 5, 0, 0, 3'b001, "lu_stall");
         checkOutput("deep_lu_hazard", 1, 3, 1);
      end
      applyStimulus(1, 1, 0, 0, 0, 0, 0, 0, 0, 3'b000, "lu_idle");
      checkOutput("deep_stall_sat", 1, 4, 7);
      for (int n = 0; n < 300; n++)
         applyStimulus(1, $urandom_range(0, 9) < 8, $urandom_range(0, 9) == 0, 1'($urandom),
                       $urandom_range(0, 7), $urandom_range(0, 2) == 0, $urandom_range(0, 7),
                       $urandom_range(0, 7), $urandom_range(0, 7), 3'($urandom), "rand1");

      @(negedge clk);
      #1;
      checks++;
      if (expq.size() != 0 || chkq.size() != 0) begin
         failures++;
         $display("[TB] FAIL drain pending=%0d required=0", expq.size() + chkq.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
